// File: rtl/pong_match_ctrl_if.sv
// Link between the match controller and the ball/paddle datapath: miss
// pulses flow up, enable/visibility/recentre/serve controls flow down.
interface pong_match_ctrl_if;
  logic miss_left;
  logic miss_right;
  logic play_en;
  logic sq_shown;
  logic pos_reset;
  logic serve_dir;

  modport master (
    input  miss_left, miss_right,
    output play_en, sq_shown, pos_reset, serve_dir
  );

  modport slave (
    output miss_left, miss_right,
    input  play_en, sq_shown, pos_reset, serve_dir
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: menu, serve delay, rally and game-over modes, scoring
// and serve direction, with synchronised raw buttons and a re-arm guard.
module pong_match_ctrl #(
  parameter int unsigned SAFE_CYC  = 2_500_000,
  parameter int unsigned SERVE_CYC = 50_352_112,
  parameter int unsigned MAX_SCORE = 11
) (
  input  logic              clk_0,
  input  logic              rst,
  input  logic [3:0]        btn_n,
  pong_match_ctrl_if.master dp,
  output logic [3:0]        score_p1,
  output logic [3:0]        score_p2,
  output logic              game_startup,
  output logic              game_over,
  output logic              winner
);

  localparam int unsigned TMAX = (SAFE_CYC > SERVE_CYC) ? SAFE_CYC : SERVE_CYC;
  localparam int          TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SAFE_T     = TW'(SAFE_CYC);
  localparam logic [TW-1:0] SERVE_LAST = TW'(SERVE_CYC - 1);
  localparam logic [3:0]    MAX_S      = 4'(MAX_SCORE);

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_SERVE_WAIT,
    ST_PLAY,
    ST_GAME_OVER
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          armed_q, armed_d;
  logic [3:0]    btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
  logic [3:0]    score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic          serve_dir_q, serve_dir_d, winner_q, winner_d;
  logic          play_en_q, play_en_d, sq_shown_q, sq_shown_d, pos_reset_q, pos_reset_d;
  logic          game_startup_q, game_startup_d, game_over_q, game_over_d;
  logic          any_btn, idle_mode;

  assign any_btn   = ~&btn_sync_q;
  assign idle_mode = (state_q == ST_STARTUP) || (state_q == ST_GAME_OVER);

  always_comb begin
    // NOTE: every _d starts from its _q (or a fixed idle value) so no path through this block can infer a latch.
    state_d        = state_q;
    timer_d        = timer_q;
    armed_d        = armed_q;
    btn_meta_d     = btn_n;
    btn_sync_d     = btn_meta_q;
    score_p1_d     = score_p1_q;
    score_p2_d     = score_p2_q;
    serve_dir_d    = serve_dir_q;
    winner_d       = winner_q;
    pos_reset_d    = 1'b0;

    unique case (state_q)
      ST_STARTUP: begin
        if (armed_q && any_btn) begin
          state_d     = ST_SERVE_WAIT;
          score_p1_d  = '0;
          score_p2_d  = '0;
          serve_dir_d = 1'b0;
          pos_reset_d = 1'b1;
        end
      end
      ST_SERVE_WAIT: begin
        if (timer_q == SERVE_LAST) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // A simultaneous double miss credits P2 only.
        if (dp.miss_left) begin
          score_p2_d  = score_p2_q + 4'd1;
          serve_dir_d = 1'b0;
          if (score_p2_d == MAX_S) begin
            state_d  = ST_GAME_OVER;
            winner_d = 1'b1;
          end else begin
            state_d     = ST_SERVE_WAIT;
            pos_reset_d = 1'b1;
          end
        end else if (dp.miss_right) begin
          score_p1_d  = score_p1_q + 4'd1;
          serve_dir_d = 1'b1;
          if (score_p1_d == MAX_S) begin
            state_d  = ST_GAME_OVER;
            winner_d = 1'b0;
          end else begin
            state_d     = ST_SERVE_WAIT;
            pos_reset_d = 1'b1;
          end
        end
      end
      ST_GAME_OVER: begin
        if (armed_q && any_btn) begin
          state_d     = ST_STARTUP;
          score_p1_d  = '0;
          score_p2_d  = '0;
          pos_reset_d = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    if (state_d != state_q)          timer_d = '0;
    else if (state_q == ST_SERVE_WAIT) timer_d = timer_q + TW'(1);
    else if (idle_mode && timer_q < SAFE_T) timer_d = timer_q + TW'(1);

    // Arming needs a quiet button after the safe window, so a held press never starts a match.
    if (state_d != state_q && (state_d == ST_STARTUP || state_d == ST_GAME_OVER))
      armed_d = 1'b0;
    else if (idle_mode && timer_q >= SAFE_T && !any_btn)
      armed_d = 1'b1;

    play_en_d      = (state_d == ST_PLAY);
    sq_shown_d     = (state_d == ST_PLAY);
    game_startup_d = (state_d == ST_STARTUP);
    game_over_d    = (state_d == ST_GAME_OVER);
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_STARTUP;
      timer_q        <= '0;
      armed_q        <= 1'b0;
      btn_meta_q     <= 4'hF;
      btn_sync_q     <= 4'hF;
      score_p1_q     <= '0;
      score_p2_q     <= '0;
      serve_dir_q    <= 1'b0;
      winner_q       <= 1'b0;
      play_en_q      <= 1'b0;
      sq_shown_q     <= 1'b0;
      pos_reset_q    <= 1'b0;
      game_startup_q <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      armed_q        <= armed_d;
      btn_meta_q     <= btn_meta_d;
      btn_sync_q     <= btn_sync_d;
      score_p1_q     <= score_p1_d;
      score_p2_q     <= score_p2_d;
      serve_dir_q    <= serve_dir_d;
      winner_q       <= winner_d;
      play_en_q      <= play_en_d;
      sq_shown_q     <= sq_shown_d;
      pos_reset_q    <= pos_reset_d;
      game_startup_q <= game_startup_d;
      game_over_q    <= game_over_d;
    end
  end

  assign dp.play_en   = play_en_q;
  assign dp.sq_shown  = sq_shown_q;
  assign dp.pos_reset = pos_reset_q;
  assign dp.serve_dir = serve_dir_q;
  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign game_startup = game_startup_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with small timing parameters; expected
// match snapshots are queued as stimulus is applied and checked on the response.
module tb_pong_match_ctrl;

  logic       clk_0 = 1'b0;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] score_p1, score_p2;
  logic       game_startup, game_over, winner;

  pong_match_ctrl_if dp_if ();

  pong_match_ctrl #(.SAFE_CYC(8), .SERVE_CYC(16), .MAX_SCORE(3)) dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .btn_n        (btn_n),
    .dp           (dp_if.master),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .game_startup (game_startup),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct {
    string      tag;
    logic [3:0] p1;
    logic [3:0] p2;
    logic       dir;
    logic       over;
    logic       win;
    logic       chk_win;
    logic       play;
    logic       startup;
    logic       posr;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   failed    = 0;
  int   pr_cnt    = 0;

  always @(posedge clk_0) begin
    #1;
    if (dp_if.pos_reset === 1'b1) pr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_0);
  endtask

  task automatic push_exp(input string tag, input logic [3:0] p1, input logic [3:0] p2,
                          input logic dir, input logic over, input logic win, input logic chk_win,
                          input logic play, input logic startup, input logic posr);
    exp_t e;
    e.tag = tag; e.p1 = p1; e.p2 = p2; e.dir = dir; e.over = over; e.win = win;
    e.chk_win = chk_win; e.play = play; e.startup = startup; e.posr = posr;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      failed++;
      $error("FAIL sb_underflow: observed empty expected entry");
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_p1"},      score_p1,        e.p1);
    check({e.tag, "_p2"},      score_p2,        e.p2);
    check({e.tag, "_dir"},     dp_if.serve_dir, e.dir);
    check({e.tag, "_over"},    game_over,       e.over);
    if (e.chk_win) check({e.tag, "_win"}, winner, e.win);
    check({e.tag, "_play"},    dp_if.play_en,   e.play);
    check({e.tag, "_shown"},   dp_if.sq_shown,  e.play);
    check({e.tag, "_startup"}, game_startup,    e.startup);
    check({e.tag, "_posr"},    dp_if.pos_reset, e.posr);
  endtask

  // Press a button until the controller answers with pos_reset, then release.
  task automatic press(input string tag);
    int n = 0;
    btn_n = 4'hE;
    while (dp_if.pos_reset !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check({tag, "_press_ack"}, dp_if.pos_reset, 1'b1);
    pop_check();
    btn_n = 4'hF;
  endtask

  task automatic wait_play(input string tag);
    int n = 0;
    while (dp_if.play_en !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_play_wait"}, dp_if.play_en, 1'b1);
  endtask

  task automatic miss(input logic l, input logic r);
    dp_if.miss_left  = l;
    dp_if.miss_right = r;
    step();
    dp_if.miss_left  = 1'b0;
    dp_if.miss_right = 1'b0;
  endtask

  initial begin
    int n;
    int pr_base;
    rst = 1'b0;
    btn_n = 4'hF;
    dp_if.miss_left  = 1'b0;
    dp_if.miss_right = 1'b0;
    step(2);

    // Reset state
    check("rst_startup", game_startup, 1'b1);
    check("rst_over",    game_over,    1'b0);
    check("rst_play",    dp_if.play_en, 1'b0);
    check("rst_posr",    dp_if.pos_reset, 1'b0);
    rst = 1'b1;

    // Test 1: early press ignored, later press starts a serve
    step(4);
    btn_n = 4'hE;
    step();
    btn_n = 4'hF;
    step(7);
    check("early_press_startup", game_startup, 1'b1);
    check("early_press_no_posr", pr_cnt, 0);
    push_exp("start1", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    press("start1");
    n = 0;
    while (dp_if.sq_shown === 1'b0 && n < 100) begin
      n++;
      step();
    end
    check("serve_hidden_cycles", n, 16);
    check("serve_play_en", dp_if.play_en, 1'b1);
    check("single_posr", pr_cnt, 1);

    // Test 2: a button held through reset never arms
    rst = 1'b0;
    btn_n = 4'h7;
    step(2);
    rst = 1'b1;
    pr_base = pr_cnt;
    step(50);
    check("held_startup", game_startup, 1'b1);
    check("held_no_posr", pr_cnt, pr_base);
    btn_n = 4'hF;
    step(4);
    push_exp("start2", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    press("start2");

    // Test 3: single misses
    wait_play("t3a");
    push_exp("miss_r", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    miss(1'b0, 1'b1);
    pop_check();
    wait_play("t3b");
    push_exp("miss_l", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    miss(1'b1, 1'b0);
    pop_check();

    // Test 4: both walls in one cycle credit P2 only
    wait_play("t4");
    push_exp("miss_both", 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    miss(1'b1, 1'b1);
    pop_check();

    // Test 5: P2 reaches MAX_SCORE, game over holds, restart to STARTUP
    wait_play("t5");
    push_exp("p2_wins", 4'd1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    miss(1'b1, 1'b0);
    pop_check();
    step(2);
    push_exp("over_hold", 4'd1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    miss(1'b0, 1'b1);
    step();
    pop_check();
    step(10);
    push_exp("restart", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    press("restart");

    // Test 6: asynchronous reset mid serve delay
    step(12);
    push_exp("start3", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    press("start3");
    wait_play("t6a");
    push_exp("p1_one", 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    miss(1'b0, 1'b1);
    pop_check();
    wait_play("t6b");
    push_exp("p1_two", 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    miss(1'b0, 1'b1);
    pop_check();
    step(5);
    pr_base = pr_cnt;
    #2;
    rst = 1'b0;
    #1;
    push_exp("async_rst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    pop_check();
    step();
    rst = 1'b1;
    step(3);
    check("rst_no_posr", pr_cnt, pr_base);
    check("rst_release_startup", game_startup, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match-level sequencer for the Pong console. Owns game mode (startup menu, serve delay, rally, game over), the scores, and serve direction. Drives the ball/paddle datapath through enable and recentre strobes, and consumes that datapath's wall-miss pulses. Button inputs are raw active-low pins, synchronised here.

Parameters:
SAFE_CYC, 2_500_000, cycles after entering STARTUP or GAME_OVER before any button press is accepted.
SERVE_CYC, 50_352_112, cycles the ball stays hidden and centred before each serve (about 2 s at 25.175 MHz).
MAX_SCORE, 11, score that ends the match (1..15).

Ports:
clk_0  in  1  25.175 MHz system clock.
rst  in  1  asynchronous active-low reset.
btn_n  in  4  raw active-low buttons {down_p2, up_p2, down_p1, up_p1}.
miss_left  in  1  1-cycle pulse: ball reached left wall (point to P2).
miss_right  in  1  1-cycle pulse: ball reached right wall (point to P1).
play_en  out  1  datapath may move ball and paddles.
sq_shown  out  1  ball visible.
pos_reset  out  1  1-cycle strobe: datapath recentres ball and paddles.
serve_dir  out  1  initial ball x direction, 0 = left, 1 = right.
score_p1  out  4  player 1 score.
score_p2  out  4  player 2 score.
game_startup  out  1  high in STARTUP.
game_over  out  1  high in GAME_OVER.
winner  out  1  0 = P1, 1 = P2; valid while game_over.

Behaviour:
- Reset (rst low, asynchronous): state STARTUP, timer 0, armed 0, scores 0, serve_dir 0, winner 0, play_en 0, sq_shown 0, pos_reset 0, game_startup 1, game_over 0, sync flops 1 (released).
- Buttons: 2-flop synchroniser per bit. any_btn = any synchronised bit low. No debounce; the arming rule below makes a bounce harmless.
- armed: cleared on entry to STARTUP and GAME_OVER. Set when timer ≥ SAFE_CYC and any_btn = 0. A held button can never start a match.
- Timer: single counter, width $clog2(max(SAFE_CYC, SERVE_CYC)+1). Cleared on every state entry. In STARTUP and GAME_OVER it counts up and saturates at SAFE_CYC.
- STARTUP: outputs idle, scores held at 0. When armed and any_btn: next cycle go to SERVE_WAIT, scores cleared, serve_dir 0, pos_reset pulses.
- SERVE_WAIT: play_en 0, sq_shown 0. Timer counts. When the timer reaches SERVE_CYC-1, the next state is PLAY. The ball is therefore hidden for exactly SERVE_CYC cycles.
- PLAY: play_en 1, sq_shown 1.
  - miss_right: score_p1 +1, serve_dir 1.
  - miss_left: score_p2 +1, serve_dir 0.
  - Both in the same cycle: miss_left wins and miss_right is dropped.
  - After scoring: if the new score equals MAX_SCORE, go to GAME_OVER and set winner (0 if P1, 1 if P2). Otherwise go to SERVE_WAIT with pos_reset pulsed.
  - play_en and sq_shown drop in the cycle after the miss pulse.
- GAME_OVER: play_en 0, sq_shown 0. Final scores and winner are held for display. When armed and any_btn, go to STARTUP: scores 0, pos_reset pulses, game_startup 1.
- Miss pulses outside PLAY are ignored.
- All outputs are registered.
- pos_reset is high for exactly one cycle, the first cycle of the new state.
- Scores never exceed MAX_SCORE and never wrap.
- Reset in any state or mid-timer returns to reset values immediately; no pos_reset pulse is generated by reset.

Test Plan:
1. Bench parameters: SAFE_CYC=8, SERVE_CYC=16, MAX_SCORE=3.
   - Release reset with btn_n=4'hF. Pulse btn_n=4'hE at cycle 4 → ignored (timer < 8).
   - Release, then press at cycle 12 → SERVE_WAIT, one pos_reset pulse, sq_shown 0 for exactly 16 cycles, then PLAY with play_en 1.
2. Hold btn_n=4'h7 from reset through cycle 50 → remains in STARTUP (never armed). Release and press again → starts.
3. In PLAY, pulse miss_right → score_p1=1, serve_dir=1, SERVE_WAIT with pos_reset. Then pulse miss_left in PLAY → score_p2=1, serve_dir=0.
4. Assert miss_left and miss_right in the same cycle → score_p2 +1 only; score_p1 unchanged.
5. Drive P2 to 3 points → game_over 1, winner 1, scores held at P1 value / 3, play_en 0.
   - Pulse miss_right in GAME_OVER → no change.
   - Release and press after 8 cycles → STARTUP, scores 0/0.
6. Assert rst low mid-SERVE_WAIT with score_p1=2 → all outputs at reset values asynchronously (before the next clock edge), state STARTUP.
